// File: rtl/bf_ctrl_pkg.sv
// Shared types and sizing for the boolean-function sweep controller.
package bf_ctrl_pkg;

  localparam int NUM_COMB = 8;
  localparam int IDX_W    = 3;
  localparam int CNT_W    = 8;
  localparam int MISS_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Count of set bits in a truth-table-wide vector; 4 bits hold the maximum of 8.
  function automatic logic [MISS_W-1:0] popcount8(input logic [NUM_COMB-1:0] v);
    logic [MISS_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_COMB; i++) begin
      n = n + MISS_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/bf_settle_cnt.sv
// Settle-time counter: counts held cycles of one input combination and flags
// the last one, after which it wraps back to zero on its own.
module bf_settle_cnt
  import bf_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic terminal_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign terminal_o = (count_q == CNT_W'(SETTLE - 1));

  // Next count: clear wins, otherwise step and wrap on the terminal cycle.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      if (terminal_o) begin
        count_d = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bf_sweep_ctrl.sv
// Sweep sequencer: drives all eight {inA,inB,inC} combinations in order, holds
// each for SETTLE cycles, captures the datapath output into a truth table and
// grades it against EXPECTED.
module bf_sweep_ctrl
  import bf_ctrl_pkg::*;
#(
  parameter int unsigned         SETTLE   = 4,
  parameter logic [NUM_COMB-1:0] EXPECTED = 8'hE8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                dut_out,
  output logic                inA,
  output logic                inB,
  output logic                inC,
  output logic                busy,
  output logic                done,
  output logic [NUM_COMB-1:0] tt,
  output logic                pass,
  output logic [MISS_W-1:0]   mismatch_cnt
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    drv_q, drv_d;
  logic [NUM_COMB-1:0] tt_q, tt_d;
  logic                pass_q, pass_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                cntClr;
  logic                cntEn;
  logic                cntTerminal;

  bf_settle_cnt #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cntClr),
    .en_i       (cntEn),
    .terminal_o (cntTerminal)
  );

  // Next-state and datapath-update logic. The grade is computed from the
  // truth table including the final sample so it is valid during FINISH.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drv_d   = '0;
    tt_d    = tt_q;
    pass_d  = pass_q;
    miss_d  = miss_q;
    cntClr  = 1'b0;
    cntEn   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_APPLY;
          idx_d   = '0;
          tt_d    = '0;
          pass_d  = 1'b0;
          miss_d  = '0;
          cntClr  = 1'b1;
        end
      end
      ST_APPLY: begin
        cntEn = 1'b1;
        drv_d = idx_q;
        if (cntTerminal) begin
          tt_d[idx_q] = dut_out;
          if (idx_q == IDX_W'(NUM_COMB - 1)) begin
            state_d = ST_FINISH;
            drv_d   = '0;
            pass_d  = (tt_d == EXPECTED);
            miss_d  = popcount8(tt_d ^ EXPECTED);
          end else begin
            idx_d = idx_q + IDX_W'(1);
            drv_d = idx_d;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, index, drive and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      drv_q   <= '0;
      tt_q    <= '0;
      pass_q  <= 1'b0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drv_q   <= drv_d;
      tt_q    <= tt_d;
      pass_q  <= pass_d;
      miss_q  <= miss_d;
    end
  end

  assign {inA, inB, inC} = drv_q;
  assign busy            = (state_q == ST_APPLY);
  assign done            = (state_q == ST_FINISH);
  assign tt              = tt_q;
  assign pass            = pass_q;
  assign mismatch_cnt    = miss_q;

endmodule

// File: tb/tb_bf_sweep_ctrl.sv
// Testbench for bf_sweep_ctrl: four instances with different settle times,
// expected patterns and datapath functions, each compared every cycle against
// a timeline model built from the sweep rules.
module tb_bf_sweep_ctrl;

  localparam int NI = 4;

  logic       clock = 1'b0;
  logic       startS [NI];
  logic       rstS   [NI];
  logic       dout   [NI];
  logic       inA    [NI];
  logic       inB    [NI];
  logic       inC    [NI];
  logic       busy   [NI];
  logic       done   [NI];
  logic       pass   [NI];
  logic [7:0] tt     [NI];
  logic [3:0] miss   [NI];

  int         setv [NI] = '{4, 1, 2, 3};
  logic [7:0] expv [NI] = '{8'hE8, 8'hE8, 8'hE8, 8'hFF};
  int         fsel [NI] = '{0, 1, 0, 2};
  logic [7:0] rtab [NI] = '{8'h00, 8'h00, 8'h00, 8'h00};

  int         ph    [NI] = '{0, 0, 0, 0};
  logic [7:0] ett   [NI] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic       epass [NI] = '{1'b0, 1'b0, 1'b0, 1'b0};
  int         emiss [NI] = '{0, 0, 0, 0};
  int         doneSeen [NI] = '{0, 0, 0, 0};

  bit checkOn = 1'b0;
  int assertCount = 0;
  int failCount = 0;

  always #5 clock = ~clock;

  // Datapath functions: majority, XOR3, constant zero, or a random table.
  function automatic logic fn(input int sel, input logic [7:0] rt, input int i);
    logic [7:0] t;
    case (sel)
      0:       t = 8'hE8;
      1:       t = 8'h96;
      2:       t = 8'h00;
      default: t = rt;
    endcase
    return t[i];
  endfunction

  assign dout[0] = fn(fsel[0], rtab[0], int'({inA[0], inB[0], inC[0]}));
  assign dout[1] = fn(fsel[1], rtab[1], int'({inA[1], inB[1], inC[1]}));
  assign dout[2] = fn(fsel[2], rtab[2], int'({inA[2], inB[2], inC[2]}));
  assign dout[3] = fn(fsel[3], rtab[3], int'({inA[3], inB[3], inC[3]}));

  bf_sweep_ctrl #(.SETTLE(4), .EXPECTED(8'hE8)) u0 (
    .clk(clock), .rst(rstS[0]), .start(startS[0]), .dut_out(dout[0]),
    .inA(inA[0]), .inB(inB[0]), .inC(inC[0]), .busy(busy[0]), .done(done[0]),
    .tt(tt[0]), .pass(pass[0]), .mismatch_cnt(miss[0]));

  bf_sweep_ctrl #(.SETTLE(1), .EXPECTED(8'hE8)) u1 (
    .clk(clock), .rst(rstS[1]), .start(startS[1]), .dut_out(dout[1]),
    .inA(inA[1]), .inB(inB[1]), .inC(inC[1]), .busy(busy[1]), .done(done[1]),
    .tt(tt[1]), .pass(pass[1]), .mismatch_cnt(miss[1]));

  bf_sweep_ctrl #(.SETTLE(2), .EXPECTED(8'hE8)) u2 (
    .clk(clock), .rst(rstS[2]), .start(startS[2]), .dut_out(dout[2]),
    .inA(inA[2]), .inB(inB[2]), .inC(inC[2]), .busy(busy[2]), .done(done[2]),
    .tt(tt[2]), .pass(pass[2]), .mismatch_cnt(miss[2]));

  bf_sweep_ctrl #(.SETTLE(3), .EXPECTED(8'hFF)) u3 (
    .clk(clock), .rst(rstS[3]), .start(startS[3]), .dut_out(dout[3]),
    .inA(inA[3]), .inB(inB[3]), .inC(inC[3]), .busy(busy[3]), .done(done[3]),
    .tt(tt[3]), .pass(pass[3]), .mismatch_cnt(miss[3]));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int k, input logic s, input logic r);
    startS[k] = s;
    rstS[k]   = r;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Timeline model: ph is the cycle number since the accepted start
  // (0 = idle). Row i is sampled at the end of cycle (i+1)*S, and FINISH is
  // cycle 8*S+1.
  always @(posedge clock) begin
    for (int k = 0; k < NI; k++) begin
      if (rstS[k]) begin
        ph[k] = 0; ett[k] = 8'h00; epass[k] = 1'b0; emiss[k] = 0;
      end else if (ph[k] == 0) begin
        if (startS[k]) begin
          ph[k] = 1; ett[k] = 8'h00; epass[k] = 1'b0; emiss[k] = 0;
        end
      end else if (ph[k] == 8 * setv[k] + 1) begin
        ph[k] = 0;
      end else begin
        if (ph[k] % setv[k] == 0) begin
          ett[k][ph[k] / setv[k] - 1] = fn(fsel[k], rtab[k], ph[k] / setv[k] - 1);
        end
        ph[k] = ph[k] + 1;
        if (ph[k] == 8 * setv[k] + 1) begin
          epass[k] = (ett[k] == expv[k]);
          emiss[k] = 0;
          for (int b = 0; b < 8; b++) begin
            if (ett[k][b] != expv[k][b]) emiss[k] = emiss[k] + 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model, away from the edge.
  always @(negedge clock) begin
    if (checkOn) begin
      for (int k = 0; k < NI; k++) begin
        bit ebusy;
        int eidx;
        ebusy = (ph[k] >= 1) && (ph[k] <= 8 * setv[k]);
        eidx  = ebusy ? (ph[k] - 1) / setv[k] : 0;
        checkOutput($sformatf("u%0d.busy", k), 32'(busy[k]), 32'(ebusy));
        checkOutput($sformatf("u%0d.done", k), 32'(done[k]), 32'(ph[k] == 8 * setv[k] + 1));
        checkOutput($sformatf("u%0d.abc", k), 32'({inA[k], inB[k], inC[k]}), 32'(eidx));
        checkOutput($sformatf("u%0d.tt", k), 32'(tt[k]), 32'(ett[k]));
        checkOutput($sformatf("u%0d.pass", k), 32'(pass[k]), 32'(epass[k]));
        checkOutput($sformatf("u%0d.miss", k), 32'(miss[k]), 32'(emiss[k]));
        if (done[k] === 1'b1) doneSeen[k]++;
      end
    end
  end

  initial begin
    for (int k = 0; k < NI; k++) applyStimulus(k, 1'b0, 1'b1);
    waitCycles(3);
    checkOn = 1'b1;
    for (int k = 0; k < NI; k++) applyStimulus(k, 1'b0, 1'b0);
    waitCycles(2);

    // Launch one sweep on each instance; u2 keeps start high for back-to-back sweeps.
    for (int k = 0; k < NI; k++) doneSeen[k] = 0;
    for (int k = 0; k < NI; k++) applyStimulus(k, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0);
    applyStimulus(3, 1'b0, 1'b0);
    // Extra start pulses on u0 at T0+5 and T0+20 must be ignored.
    waitCycles(4);
    applyStimulus(0, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(0, 1'b0, 1'b0);
    waitCycles(14);
    applyStimulus(0, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(0, 1'b0, 1'b0);
    waitCycles(25);
    applyStimulus(2, 1'b0, 1'b0);

    checkOutput("t1.u0.tt", 32'(tt[0]), 32'h0E8);
    checkOutput("t1.u0.pass", 32'(pass[0]), 32'd1);
    checkOutput("t1.u0.miss", 32'(miss[0]), 32'd0);
    checkOutput("t3.u0.doneCount", 32'(doneSeen[0]), 32'd1);
    // XOR3 table 96 against E8: 96 ^ E8 = 7E, six differing rows.
    checkOutput("t2.u1.tt", 32'(tt[1]), 32'h096);
    checkOutput("t2.u1.pass", 32'(pass[1]), 32'd0);
    checkOutput("t2.u1.miss", 32'(miss[1]), 32'd6);
    checkOutput("t6.u3.tt", 32'(tt[3]), 32'h000);
    checkOutput("t6.u3.pass", 32'(pass[3]), 32'd0);
    checkOutput("t6.u3.miss", 32'(miss[3]), 32'd8);
    waitCycles(20);

    // Reset u0 at T0+10 of a sweep, then run a clean sweep.
    applyStimulus(0, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(0, 1'b0, 1'b0);
    waitCycles(9);
    applyStimulus(0, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("t4.u0.busy", 32'(busy[0]), 32'd0);
    checkOutput("t4.u0.abc", 32'({inA[0], inB[0], inC[0]}), 32'd0);
    waitCycles(2);
    applyStimulus(0, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(0, 1'b0, 1'b0);
    waitCycles(40);
    checkOutput("t4.u0.tt", 32'(tt[0]), 32'h0E8);
    checkOutput("t4.u0.pass", 32'(pass[0]), 32'd1);

    // Random phase: random tables changing at any time, random starts and resets.
    for (int k = 0; k < NI; k++) begin
      fsel[k] = 3;
      rtab[k] = 8'($urandom);
    end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NI; k++) begin
        applyStimulus(k, ($urandom % 4) == 0, ($urandom % 150) == 0);
        if (($urandom % 16) == 0) rtab[k] = 8'($urandom);
        if (($urandom % 500) == 0) rtab[k] = expv[k];
      end
      waitCycles(1);
    end
    for (int k = 0; k < NI; k++) applyStimulus(k, 1'b0, 1'b0);
    waitCycles(40);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
